// File: rtl/spi_txn_arb.sv
// Round-robin arbiter/sequencer sharing one 16-bit SPI master among NUM_REQ requesters.
// Optional transaction watchdog with DRAIN recovery: define SPI_TXN_ARB_TIMEOUT_EN.
module spi_txn_arb #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [16*NUM_REQ-1:0] req_cmd_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    resp_vld_o,
  output logic [15:0]           resp_data_o,
  output logic                  resp_err_o,
  output logic                  wrt_o,
  output logic [15:0]           cmd_o,
  input  logic                  done_i,
  input  logic [15:0]           rd_data_i
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_BUSY   = 3'd2,
    S_RESP   = 3'd3
`ifdef SPI_TXN_ARB_TIMEOUT_EN
    , S_DRAIN = 3'd4
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   resp_vld_q, resp_vld_d;
  logic [15:0]          resp_data_q, resp_data_d;
  logic                 wrt_q, wrt_d;
  logic [15:0]          cmd_q, cmd_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [PW-1:0]        sel_q, sel_d;

  logic                 hi_found_s, lo_found_s, any_req_s;
  logic [PW-1:0]        hi_idx_s, lo_idx_s, pick_s;
  logic [NUM_REQ-1:0]   pick_oh_s;
  logic [15:0]          cmd_sel_s;

`ifdef SPI_TXN_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_FIRE = 16'(TIMEOUT - 2);
  logic [15:0]          wd_q, wd_d;
  logic                 resp_err_q, resp_err_d;
`endif

  // Requests above rr_q take precedence over those at or below it; lowest index wins within each half.
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_idx_s   = '0;
    cmd_sel_s  = 16'h0000;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      hi_found_s = hi_found_s | (req_i[i] && (i > int'(rr_q)));
      hi_idx_s   = (req_i[i] && (i > int'(rr_q))) ? PW'(i) : hi_idx_s;
      lo_found_s = lo_found_s | (req_i[i] && (i <= int'(rr_q)));
      lo_idx_s   = (req_i[i] && (i <= int'(rr_q))) ? PW'(i) : lo_idx_s;
    end
    pick_s    = hi_found_s ? hi_idx_s : lo_idx_s;
    any_req_s = hi_found_s | lo_found_s;
    pick_oh_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
    for (int i = 0; i < NUM_REQ; i++) begin
      cmd_sel_s = (PW'(i) == pick_s) ? req_cmd_i[16*i +: 16] : cmd_sel_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    resp_vld_d  = '0;
    resp_data_d = resp_data_q;
    wrt_d       = 1'b0;
    cmd_d       = cmd_q;
    rr_d        = rr_q;
    sel_d       = sel_q;
`ifdef SPI_TXN_ARB_TIMEOUT_EN
    wd_d        = wd_q;
    resp_err_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req_s) begin
          sel_d   = pick_s;
          gnt_d   = pick_oh_s;
          cmd_d   = cmd_sel_s;
          wrt_d   = 1'b1;
          state_d = S_LAUNCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        state_d = S_BUSY;
`ifdef SPI_TXN_ARB_TIMEOUT_EN
        wd_d    = 16'h0000;
`endif
      end
      S_BUSY: begin
        if (done_i) begin
          resp_data_d = rd_data_i;
          resp_vld_d  = gnt_q;
          state_d     = S_RESP;
        end
`ifdef SPI_TXN_ARB_TIMEOUT_EN
        // Counter would reach TIMEOUT-1 on this edge: answer with an error instead.
        else if (wd_q == WD_FIRE) begin
          resp_data_d = 16'h0000;
          resp_err_d  = 1'b1;
          resp_vld_d  = gnt_q;
          rr_d        = sel_q;
          gnt_d       = '0;
          state_d     = S_DRAIN;
        end
`endif
        else begin
          state_d = S_BUSY;
`ifdef SPI_TXN_ARB_TIMEOUT_EN
          wd_d    = wd_q + 16'd1;
`endif
        end
      end
      S_RESP: begin
        rr_d    = sel_q;
        gnt_d   = '0;
        state_d = S_IDLE;
      end
`ifdef SPI_TXN_ARB_TIMEOUT_EN
      S_DRAIN: begin
        if (done_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
`endif
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      resp_vld_q  <= '0;
      resp_data_q <= 16'h0000;
      wrt_q       <= 1'b0;
      cmd_q       <= 16'h0000;
      rr_q        <= PW'(NUM_REQ - 1);
      sel_q       <= '0;
`ifdef SPI_TXN_ARB_TIMEOUT_EN
      wd_q        <= 16'h0000;
      resp_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      resp_vld_q  <= resp_vld_d;
      resp_data_q <= resp_data_d;
      wrt_q       <= wrt_d;
      cmd_q       <= cmd_d;
      rr_q        <= rr_d;
      sel_q       <= sel_d;
`ifdef SPI_TXN_ARB_TIMEOUT_EN
      wd_q        <= wd_d;
      resp_err_q  <= resp_err_d;
`endif
    end
  end

  assign gnt_o       = gnt_q;
  assign resp_vld_o  = resp_vld_q;
  assign resp_data_o = resp_data_q;
  assign wrt_o       = wrt_q;
  assign cmd_o       = cmd_q;
`ifdef SPI_TXN_ARB_TIMEOUT_EN
  assign resp_err_o  = resp_err_q;
`else
  assign resp_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_txn_arb.sv
// Randomized self-checking bench for spi_txn_arb against a transaction-level round-robin model.
module tb_spi_txn_arb;
  localparam int N = 3;
`ifdef SPI_TXN_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [16*N-1:0] req_cmd;
  logic [N-1:0]    gnt, resp_vld;
  logic [15:0]     resp_data, cmd, rd_data;
  logic            resp_err, wrt, done;

  spi_txn_arb #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_cmd_i(req_cmd),
    .gnt_o(gnt), .resp_vld_o(resp_vld), .resp_data_o(resp_data), .resp_err_o(resp_err),
    .wrt_o(wrt), .cmd_o(cmd), .done_i(done), .rd_data_i(rd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int rr_m;
  logic [N-1:0] pend;
  logic [15:0]  cmds [N];
  int wrt_cnt = 0;
  int txn_cnt = 0;
  logic [15:0]  last_rd;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: first pending requester after the last one served, cyclically.
  function automatic int model_pick();
    for (int k = 1; k <= N; k++) begin
      if (pend[(rr_m + k) % N]) return (rr_m + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_req();
    req = pend;
    for (int i = 0; i < N; i++) req_cmd[16*i +: 16] = cmds[i];
  endtask

  always @(negedge clk) begin
    if (wrt === 1'b1) wrt_cnt++;
    check_val("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
  end

  // Called at a negedge with the DUT idle (or about to be); returns at the IDLE negedge after the response.
  task automatic do_txn(input int dly, input logic [15:0] rd, input bit early_done,
                        output logic [N-1:0] gnt_seen);
    int sel, n;
    logic [N-1:0] oh;
    sel = model_pick();
    oh  = N'(1) << sel;
    drive_req();
    n = 0;
    do begin @(negedge clk); n++; end while (wrt !== 1'b1 && n < 20);
    check_val("wrt_latency", n, 1);
    check_val("gnt_launch", gnt, oh);
    check_val("cmd", cmd, cmds[sel]);
    gnt_seen = gnt;
    txn_cnt++;
    if (early_done) begin done = 1'b1; rd_data = ~rd; end
    @(negedge clk);
    done = 1'b0;
    check_val("wrt_one_cycle", wrt, 0);
    for (int i = 1; i < dly; i++) begin
      check_val("busy_no_vld", resp_vld, 0);
      @(negedge clk);
    end
    check_val("gnt_busy", gnt, oh);
    done = 1'b1;
    rd_data = rd;
    @(negedge clk);
    done = 1'b0;
    check_val("resp_vld", resp_vld, oh);
    check_val("resp_data", resp_data, rd);
    check_val("resp_err", resp_err, 0);
    check_val("gnt_resp", gnt, oh);
    last_rd = rd;
    pend[sel] = 1'b0;
    rr_m = sel;
    req = pend;
    @(negedge clk);
    check_val("vld_one_cycle", resp_vld, 0);
    check_val("gnt_cleared", gnt, 0);
  endtask

  task automatic idle_done_probe();
    repeat (2) @(negedge clk);
    done = 1'b1;
    rd_data = 16'hBEEF;
    @(negedge clk);
    done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_val("idle_done_vld", resp_vld, 0);
      check_val("idle_done_data", resp_data, last_rd);
      check_val("idle_done_wrt", wrt, 0);
    end
  endtask

  initial begin
    logic [N-1:0] g, newb;
    int n, w0;
    rst = 1'b1; req = '0; req_cmd = '0; done = 1'b0; rd_data = 16'h0000;
    pend = '0; rr_m = N - 1; last_rd = 16'h0000;
    for (int i = 0; i < N; i++) cmds[i] = 16'h0000;
    repeat (3) @(negedge clk);
    check_val("rst_gnt", gnt, 0);
    check_val("rst_wrt", wrt, 0);
    check_val("rst_vld", resp_vld, 0);
    check_val("rst_cmd", cmd, 16'h0000);
    check_val("rst_data", resp_data, 16'h0000);
    check_val("rst_err", resp_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic transaction
    pend = 3'b001; cmds[0] = 16'hA5F0;
    do_txn(5, 16'h1234, 1'b0, g);
    check_val("basic_gnt", g, 3'b001);

    idle_done_probe();

    // Serve 1, then 0 and 1 together: pointer wraps to 0
    pend = 3'b010; cmds[1] = 16'h0111;
    do_txn(2, 16'h2222, 1'b0, g);
    check_val("serve1", g, 3'b010);
    @(negedge clk);
    pend = 3'b011; cmds[0] = 16'h0100;
    do_txn(3, 16'h3333, 1'b0, g);
    check_val("wrap_to_0", g, 3'b001);
    pend = '0; req = '0;

    // Reset while BUSY
    @(negedge clk);
    pend = 3'b100; cmds[2] = 16'h0C0C;
    drive_req();
    n = 0;
    do begin @(negedge clk); n++; end while (wrt !== 1'b1 && n < 20);
    check_val("rstb_wrt_seen", n, 1);
    txn_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rstb_gnt", gnt, 0);
    check_val("rstb_wrt", wrt, 0);
    @(negedge clk);
    rst = 1'b0; pend = '0; req = '0; rr_m = N - 1; last_rd = 16'h0000;
    done = 1'b1; rd_data = 16'h1111;
    @(negedge clk);
    done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("rstb_no_vld", resp_vld, 0);
      check_val("rstb_no_wrt", wrt, 0);
    end

    // Fairness: everyone held, each drops only for the cycle after its response
    for (int k = 0; k < 6; k++) begin
      pend = (k == 0) ? 3'b111 : (3'b111 & ~(N'(1) << rr_m));
      for (int i = 0; i < N; i++) cmds[i] = 16'(16'hF000 + 16'(k * 16 + i));
      do_txn(1 + k % 3, 16'(16'h5000 + 16'(k)), 1'b0, g);
      check_val("rr_order", g, N'(1) << (k % N));
    end
    pend = '0; req = '0;

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      if (pend == '0) begin
        idle_done_probe();
        pend = N'($urandom_range(1, (1 << N) - 1));
        for (int i = 0; i < N; i++) cmds[i] = 16'($urandom);
      end
      do_txn($urandom_range(1, 6), 16'($urandom), ($urandom_range(0, 3) == 0), g);
      newb = N'($urandom) & ~pend & ~(N'(1) << rr_m);
      for (int i = 0; i < N; i++) if (newb[i]) cmds[i] = 16'($urandom);
      pend = pend | newb;
    end
    pend = '0; req = '0;

`ifdef SPI_TXN_ARB_TIMEOUT_EN
    // Watchdog: no done, error response, DRAIN until the late done
    @(negedge clk);
    pend = 3'b001; cmds[0] = 16'h7E57;
    drive_req();
    n = 0;
    do begin @(negedge clk); n++; end while (wrt !== 1'b1 && n < 20);
    check_val("to_wrt_seen", n, 1);
    txn_cnt++;
    w0 = 0;
    do begin @(negedge clk); w0++; end while (resp_vld === '0 && w0 < 40);
    check_val("to_latency", w0, TO);
    check_val("to_vld", resp_vld, 3'b001);
    check_val("to_err", resp_err, 1);
    check_val("to_data", resp_data, 16'h0000);
    rr_m = 0; pend = '0; req = '0; last_rd = 16'h0000;
    @(negedge clk);
    check_val("to_vld_one", resp_vld, 0);
    pend = 3'b010; cmds[1] = 16'h4321;
    drive_req();
    repeat (5) begin
      @(negedge clk);
      check_val("drain_no_wrt", wrt, 0);
      check_val("drain_gnt", gnt, 0);
    end
    done = 1'b1; rd_data = 16'h9999;
    @(negedge clk);
    done = 1'b0;
    do_txn(2, 16'h6543, 1'b0, g);
    check_val("after_drain", g, 3'b010);
    pend = '0; req = '0;
`endif

    repeat (2) @(negedge clk);
    check_val("wrt_per_txn", wrt_cnt, txn_cnt);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
